// File: rtl/cmd_decoder_seq.sv
// cmd_decoder_seq: sequential terminal-command decoder.
// Accepts one ASCII command word per handshake and classifies it as either
// "<D digits><op><D digits>" arithmetic or a 5-character keyword padded with
// spaces. It then emits registered operands, a one-hot opcode, go, a held
// reset request and a one-cycle out_valid strobe.
// Build option: define UNKNOWN_CMD_ERR_EN so unrecognised commands report
// opcode bit 10. Without it they are silently dropped.
module cmd_decoder_seq #(
  parameter int DIGITS     = 2,
  parameter int OPW        = 8,
  parameter int OPC_W      = 11,
  parameter int RESET_HOLD = 4,
  localparam int CW        = 8 * (2 * DIGITS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CW-1:0]    command,
  output logic [OPW-1:0]   a_in,
  output logic [OPW-1:0]   b_in,
  output logic [OPC_W-1:0] op_code,
  output logic             reset_out,
  output logic             go,
  output logic             out_valid,
  output logic             ovf
);

  localparam int NCH = 2 * DIGITS + 1;
  localparam int DCW = $clog2(DIGITS + 1);
  localparam int HCW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int AW  = OPW + 4;
  localparam logic [AW-1:0] ACC_MAX = {4'b0000, {OPW{1'b1}}};

  localparam logic [OPC_W-1:0] OPC_ADD   = OPC_W'(11'h001);
  localparam logic [OPC_W-1:0] OPC_SUB   = OPC_W'(11'h002);
  localparam logic [OPC_W-1:0] OPC_MUL   = OPC_W'(11'h004);
  localparam logic [OPC_W-1:0] OPC_DIV   = OPC_W'(11'h008);
  localparam logic [OPC_W-1:0] OPC_LAZER = OPC_W'(11'h010);
  localparam logic [OPC_W-1:0] OPC_TALK  = OPC_W'(11'h020);
  localparam logic [OPC_W-1:0] OPC_START = OPC_W'(11'h040);
  localparam logic [OPC_W-1:0] OPC_FACE  = OPC_W'(11'h080);
  localparam logic [OPC_W-1:0] OPC_FIGHT = OPC_W'(11'h100);
  localparam logic [OPC_W-1:0] OPC_ERR   = OPC_W'(11'h400);

  typedef enum logic [2:0] {IDLE, CLASSIFY, PARSE, EMIT, RST_HOLD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cmd_q, cmd_d;
  logic [AW-1:0]    acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic             sat_q, sat_d;
  logic [DCW-1:0]   dig_cnt_q, dig_cnt_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic             pend_arith_q, pend_arith_d;
  logic [OPC_W-1:0] pend_opc_q, pend_opc_d;
  logic [OPW-1:0]   a_in_q, a_in_d, b_in_q, b_in_d;
  logic [OPC_W-1:0] op_code_q, op_code_d;
  logic             reset_out_q, reset_out_d;
  logic             go_q, go_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  logic             digits_ok, tail_ok;
  logic [OPC_W-1:0] arith_opc;
  logic [CW-1:0]    scan;
  logic             kw_hit, kw_go, kw_keep, kw_rst;
  logic [OPC_W-1:0] kw_opc;
  logic [OPW-1:0]   kw_a;
  logic [AW:0]      step_a, step_b;

  // One decimal step with clamping; the top bit flags that the clamp fired.
  function automatic logic [AW:0] digit_step(input logic [AW-1:0] acc, input logic [7:0] ch);
    logic [AW-1:0] nxt;
    nxt = acc * AW'(10) + AW'(ch[3:0]);
    if (nxt > ACC_MAX) return {1'b1, ACC_MAX};
    return {1'b0, nxt};
  endfunction

  // Operand A digits sit at the top of cmd_q, and operand B digits sit just
  // past the operator. PARSE shifts cmd_q so both digit columns advance together.
  assign step_a = digit_step(acc_a_q, cmd_q[CW-1 -: 8]);
  assign step_b = digit_step(acc_b_q, cmd_q[CW-1-8*(DIGITS+1) -: 8]);

  // Character-class scan: digit positions, the operator and the keyword space tail.
  always_comb begin
    digits_ok = 1'b1;
    tail_ok   = 1'b1;
    arith_opc = '0;
    scan      = cmd_q;
    for (int i = 0; i < NCH; i++) begin
      if (i != DIGITS && (scan[CW-1 -: 8] < 8'h30 || scan[CW-1 -: 8] > 8'h39)) digits_ok = 1'b0;
      if (i >= 5 && scan[CW-1 -: 8] != 8'h20) tail_ok = 1'b0;
      scan = scan << 8;
    end
    case (cmd_q[CW-1-8*DIGITS -: 8])
      8'h2B:        arith_opc = OPC_ADD;
      8'h2D:        arith_opc = OPC_SUB;
      8'h2A, 8'h78: arith_opc = OPC_MUL;
      8'h2F:        arith_opc = OPC_DIV;
      default:      arith_opc = '0;
    endcase
  end

  // Keyword table lookup on the first five characters of the held command.
  always_comb begin
    kw_hit  = 1'b1;
    kw_opc  = '0;
    kw_a    = '0;
    kw_go   = 1'b0;
    kw_keep = 1'b0;
    kw_rst  = 1'b0;
    case (cmd_q[CW-1 -: 40])
      "lazer": kw_opc = OPC_LAZER;
      "hello": kw_opc = OPC_TALK;
      "how  ": begin kw_opc = OPC_TALK; kw_a = OPW'(1); end
      "hey  ": begin kw_opc = OPC_TALK; kw_a = OPW'(2); end
      "sup  ": begin kw_opc = OPC_TALK; kw_a = OPW'(3); end
      "pirat": begin kw_opc = OPC_TALK; kw_a = OPW'(4); end
      "what ": begin kw_opc = OPC_TALK; kw_a = OPW'(5); end
      "arggg": begin kw_opc = OPC_TALK; kw_a = OPW'(6); end
      "i nee": begin kw_opc = OPC_TALK; kw_a = OPW'(7); end
      "start": begin kw_opc = OPC_START; kw_go = 1'b1; end
      "smile": begin kw_opc = OPC_FACE; kw_a = OPW'(2); end
      "raves": kw_opc = OPC_FACE;
      "fight": kw_opc = OPC_FIGHT;
      "disco": kw_opc = '0;
      "reset": begin kw_opc = OPC_FIGHT; kw_rst = 1'b1; end
      "stop ": begin kw_a = OPW'(1); kw_go = 1'b1; kw_keep = 1'b1; end
      default: kw_hit = 1'b0;
    endcase
  end

  // Next-state and output logic. Everything holds unless a state updates it,
  // and out_valid is a single-cycle strobe.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    acc_a_d      = acc_a_q;
    acc_b_d      = acc_b_q;
    sat_d        = sat_q;
    dig_cnt_d    = dig_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    pend_arith_d = pend_arith_q;
    pend_opc_d   = pend_opc_q;
    a_in_d       = a_in_q;
    b_in_d       = b_in_q;
    op_code_d    = op_code_q;
    reset_out_d  = reset_out_q;
    go_d         = go_q;
    out_valid_d  = 1'b0;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d   = command;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        if (digits_ok && arith_opc != '0) begin
          pend_arith_d = 1'b1;
          pend_opc_d   = arith_opc;
          acc_a_d      = '0;
          acc_b_d      = '0;
          sat_d        = 1'b0;
          dig_cnt_d    = '0;
          state_d      = PARSE;
        end else if (kw_hit && tail_ok) begin
          pend_arith_d = 1'b0;
          state_d      = EMIT;
        end else begin
`ifdef UNKNOWN_CMD_ERR_EN
          pend_arith_d = 1'b0;
          state_d      = EMIT;
`else
          state_d      = IDLE;
`endif
        end
      end
      PARSE: begin
        acc_a_d = step_a[AW-1:0];
        acc_b_d = step_b[AW-1:0];
        sat_d   = sat_q | step_a[AW] | step_b[AW];
        cmd_d   = cmd_q << 8;
        if (dig_cnt_q == DCW'(DIGITS - 1)) state_d = EMIT;
        else dig_cnt_d = dig_cnt_q + 1'b1;
      end
      EMIT: begin
        out_valid_d = 1'b1;
        state_d     = IDLE;
        if (pend_arith_q) begin
          a_in_d      = acc_a_q[OPW-1:0];
          b_in_d      = acc_b_q[OPW-1:0];
          op_code_d   = pend_opc_q;
          go_d        = 1'b0;
          ovf_d       = sat_q;
          reset_out_d = 1'b0;
        end else if (kw_hit && tail_ok) begin
          a_in_d      = kw_a;
          b_in_d      = '0;
          op_code_d   = kw_keep ? op_code_q : kw_opc;
          go_d        = kw_go;
          ovf_d       = 1'b0;
          reset_out_d = kw_rst;
          if (kw_rst) begin
            hold_cnt_d = '0;
            state_d    = RST_HOLD;
          end
        end else begin
          a_in_d      = '0;
          b_in_d      = '0;
          op_code_d   = OPC_ERR;
          go_d        = 1'b0;
          ovf_d       = 1'b0;
          reset_out_d = 1'b0;
        end
      end
      RST_HOLD: begin
        if (hold_cnt_q == HCW'(RESET_HOLD - 1)) begin
          reset_out_d = 1'b0;
          hold_cnt_d  = '0;
          state_d     = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      sat_q        <= 1'b0;
      dig_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      pend_arith_q <= 1'b0;
      pend_opc_q   <= '0;
      a_in_q       <= '0;
      b_in_q       <= '0;
      op_code_q    <= '0;
      reset_out_q  <= 1'b0;
      go_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      acc_a_q      <= acc_a_d;
      acc_b_q      <= acc_b_d;
      sat_q        <= sat_d;
      dig_cnt_q    <= dig_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      pend_arith_q <= pend_arith_d;
      pend_opc_q   <= pend_opc_d;
      a_in_q       <= a_in_d;
      b_in_q       <= b_in_d;
      op_code_q    <= op_code_d;
      reset_out_q  <= reset_out_d;
      go_q         <= go_d;
      out_valid_q  <= out_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign a_in      = a_in_q;
  assign b_in      = b_in_q;
  assign op_code   = op_code_q;
  assign reset_out = reset_out_q;
  assign go        = go_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cmd_decoder_seq.sv
// Testbench for cmd_decoder_seq: a behavioural command model predicts every
// output on every cycle. Directed commands pin the model to hand-computed
// values, and random commands then exercise it broadly.
module tb_cmd_decoder_seq;

  localparam int DIGITS     = 3;
  localparam int OPW        = 8;
  localparam int OPC_W      = 11;
  localparam int RESET_HOLD = 4;
  localparam int NCH        = 2 * DIGITS + 1;
  localparam int CW         = 8 * NCH;

  localparam int K_ARITH = 0;
  localparam int K_KW    = 1;
  localparam int K_UNK   = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CW-1:0]    command = '0;
  logic [OPW-1:0]   a_in;
  logic [OPW-1:0]   b_in;
  logic [OPC_W-1:0] op_code;
  logic             reset_out;
  logic             go;
  logic             out_valid;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  bit armed = 1'b0;
  int exp_ready, exp_valid, exp_a, exp_b, exp_op, exp_go, exp_rst, exp_ovf;

  cmd_decoder_seq #(
    .DIGITS(DIGITS), .OPW(OPW), .OPC_W(OPC_W), .RESET_HOLD(RESET_HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .command(command), .a_in(a_in), .b_in(b_in), .op_code(op_code),
    .reset_out(reset_out), .go(go), .out_valid(out_valid), .ovf(ovf)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // The compare process checks every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("a_in",      32'(a_in),      32'(exp_a));
      checkOutput("b_in",      32'(b_in),      32'(exp_b));
      checkOutput("op_code",   32'(op_code),   32'(exp_op));
      checkOutput("go",        32'(go),        32'(exp_go));
      checkOutput("reset_out", 32'(reset_out), 32'(exp_rst));
      checkOutput("ovf",       32'(ovf),       32'(exp_ovf));
    end
  end

  // Build a command word from text, padding with spaces.
  function automatic logic [CW-1:0] mk(input string s);
    logic [CW-1:0] r = '0;
    for (int i = 0; i < NCH; i++) begin
      r = r << 8;
      r[7:0] = (i < s.len()) ? s[i] : 8'h20;
    end
    return r;
  endfunction

  // Behavioural model: what one command must produce.
  task automatic predict(input logic [CW-1:0] c, output int kind, output int pa, output int pb,
                         output int pop, output int pgo, output int prst, output int povf,
                         output int pkeep);
    byte unsigned ch [NCH];
    logic [CW-1:0] t;
    logic [39:0] k5;
    logic [39:0] greet [8];
    bit digs, tail;
    int opv, va, vb, mx, gi;
    greet = '{"hello", "how  ", "hey  ", "sup  ", "pirat", "what ", "arggg", "i nee"};
    t = c;
    for (int i = 0; i < NCH; i++) begin
      ch[i] = t[CW-1 -: 8];
      t = t << 8;
    end
    pa = 0; pb = 0; pop = 0; pgo = 0; prst = 0; povf = 0; pkeep = 0;
    digs = 1'b1;
    for (int i = 0; i < NCH; i++)
      if (i != DIGITS && !(ch[i] >= 8'd48 && ch[i] <= 8'd57)) digs = 1'b0;
    case (ch[DIGITS])
      "+":      opv = 1;
      "-":      opv = 2;
      "*", "x": opv = 4;
      "/":      opv = 8;
      default:  opv = 0;
    endcase
    if (digs && opv != 0) begin
      va = 0; vb = 0;
      for (int i = 0; i < DIGITS; i++) begin
        va = va * 10 + (int'(ch[i]) - 48);
        vb = vb * 10 + (int'(ch[DIGITS + 1 + i]) - 48);
      end
      mx   = (1 << OPW) - 1;
      pa   = (va > mx) ? mx : va;
      pb   = (vb > mx) ? mx : vb;
      povf = (va > mx || vb > mx) ? 1 : 0;
      pop  = opv;
      kind = K_ARITH;
      return;
    end
    tail = 1'b1;
    for (int i = 5; i < NCH; i++) if (ch[i] != 8'd32) tail = 1'b0;
    k5   = c[CW-1 -: 40];
    kind = K_KW;
    gi   = -1;
    for (int g = 0; g < 8; g++) if (k5 == greet[g]) gi = g;
    if (!tail) kind = K_UNK;
    else if (gi >= 0) begin pop = 32'h020; pa = gi; end
    else if (k5 == "lazer") pop = 32'h010;
    else if (k5 == "start") begin pop = 32'h040; pgo = 1; end
    else if (k5 == "smile") begin pop = 32'h080; pa = 2; end
    else if (k5 == "raves") pop = 32'h080;
    else if (k5 == "fight") pop = 32'h100;
    else if (k5 == "disco") pop = 0;
    else if (k5 == "reset") begin pop = 32'h100; prst = 1; end
    else if (k5 == "stop ") begin pa = 1; pgo = 1; pkeep = 1; end
    else kind = K_UNK;
    if (kind == K_UNK) begin
      pa = 0; pgo = 0; prst = 0; pop = 32'h400;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    exp_valid = 0;
  endtask

  function automatic logic [CW-1:0] randomBits();
    logic [CW-1:0] r = '0;
    for (int i = 0; i < NCH; i++) r = (r << 8) | CW'($urandom_range(0, 255));
    return r;
  endfunction

  // While the decoder is busy, cmd_valid may be held high with junk that must be ignored.
  task automatic busyNoise();
    cmd_valid = 1'($urandom_range(0, 1));
    command   = randomBits();
  endtask

  task automatic setExpZero();
    exp_ready = 1; exp_valid = 0; exp_a = 0; exp_b = 0;
    exp_op = 0; exp_go = 0; exp_rst = 0; exp_ovf = 0;
  endtask

  task automatic doReset(input int n);
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    tick();
    setExpZero();
    armed = 1'b1;
    repeat (n - 1) tick();
    reset_n = 1'b1;
  endtask

  // Send one command. Call at posedge+1 while the decoder is idle; returns at
  // posedge+1 once it is idle again.
  task automatic applyStimulus(input logic [CW-1:0] c);
    int kind, pa, pb, pop, pgo, prst, povf, pkeep;
    predict(c, kind, pa, pb, pop, pgo, prst, povf, pkeep);
    cmd_valid = 1'b1;
    command   = c;
    tick();
    exp_ready = 0;
    busyNoise();
    if (kind == K_ARITH) begin
      repeat (DIGITS + 1) begin tick(); busyNoise(); end
    end else begin
`ifdef UNKNOWN_CMD_ERR_EN
      tick(); busyNoise();
`else
      if (kind != K_UNK) begin tick(); busyNoise(); end
`endif
    end
    tick();
    cmd_valid = 1'b0;
    exp_ready = 1;
`ifndef UNKNOWN_CMD_ERR_EN
    if (kind == K_UNK) return;
`endif
    exp_valid = 1;
    exp_a   = pa;
    exp_b   = pb;
    exp_go  = pgo;
    exp_ovf = povf;
    exp_rst = prst;
    if (pkeep == 0) exp_op = pop;
    if (prst != 0) begin
      exp_ready = 0;
      busyNoise();
      repeat (RESET_HOLD - 1) begin tick(); busyNoise(); end
      tick();
      cmd_valid = 1'b0;
      exp_rst   = 0;
      exp_ready = 1;
    end
  endtask

  task automatic genCmd(output logic [CW-1:0] c);
    string kws [16];
    string ops;
    byte unsigned arr [NCH];
    int sel;
    kws = '{"lazer", "hello", "how", "hey", "sup", "pirat", "what", "arggg",
            "i nee", "start", "smile", "raves", "fight", "disco", "reset", "stop"};
    ops = "+-*x/";
    sel = $urandom_range(0, 9);
    if (sel <= 3 || sel == 8) begin
      for (int i = 0; i < NCH; i++) arr[i] = byte'(48 + $urandom_range(0, 9));
      arr[DIGITS] = ops[$urandom_range(0, 4)];
      if (sel == 8) arr[$urandom_range(0, NCH - 1)] = byte'($urandom_range(0, 255));
      c = '0;
      for (int i = 0; i < NCH; i++) c = (c << 8) | CW'(arr[i]);
    end else if (sel <= 6) begin
      c = mk(kws[$urandom_range(0, 15)]);
    end else if (sel == 7) begin
      c = mk(kws[$urandom_range(0, 15)]);
      if ($urandom_range(0, 1) == 0) c[7:0] = 8'($urandom_range(33, 126));
      else c[CW-1 -: 8] = 8'($urandom_range(33, 126));
    end else begin
      c = randomBits();
    end
  endtask

  initial begin
    logic [CW-1:0] rc;
    int kind, pa, pb, pop, pgo, prst, povf, pkeep;
    $display("[TB] start");
    doReset(3);
    checkOutput("pin_reset_ready", 32'(cmd_ready), 32'd1);

    applyStimulus(mk("012+034"));
    checkOutput("pin_add_valid", 32'(out_valid), 32'd1);
    checkOutput("pin_add_a", 32'(a_in), 32'd12);
    checkOutput("pin_add_b", 32'(b_in), 32'd34);
    checkOutput("pin_add_op", 32'(op_code), 32'h001);
    repeat (2) tick();

    applyStimulus(mk("099x007"));
    checkOutput("pin_mul_a", 32'(a_in), 32'd99);
    checkOutput("pin_mul_b", 32'(b_in), 32'd7);
    checkOutput("pin_mul_op", 32'(op_code), 32'h004);

    applyStimulus(mk("999/001"));
    checkOutput("pin_div_a", 32'(a_in), 32'd255);
    checkOutput("pin_div_b", 32'(b_in), 32'd1);
    checkOutput("pin_div_ovf", 32'(ovf), 32'd1);
    checkOutput("pin_div_op", 32'(op_code), 32'h008);

    applyStimulus(mk("start"));
    checkOutput("pin_start_op", 32'(op_code), 32'h040);
    checkOutput("pin_start_go", 32'(go), 32'd1);
    checkOutput("pin_start_ovf", 32'(ovf), 32'd0);

    applyStimulus(mk("stop"));
    checkOutput("pin_stop_a", 32'(a_in), 32'd1);
    checkOutput("pin_stop_go", 32'(go), 32'd1);
    checkOutput("pin_stop_op", 32'(op_code), 32'h040);

    applyStimulus(mk("hey"));
    checkOutput("pin_hey_a", 32'(a_in), 32'd2);
    checkOutput("pin_hey_op", 32'(op_code), 32'h020);

    applyStimulus(mk("reset"));
    checkOutput("pin_rst_op", 32'(op_code), 32'h100);
    checkOutput("pin_rst_ready", 32'(cmd_ready), 32'd1);

    applyStimulus(mk("qqqqq"));
`ifdef UNKNOWN_CMD_ERR_EN
    checkOutput("pin_unk_op", 32'(op_code), 32'h400);
`else
    checkOutput("pin_unk_op", 32'(op_code), 32'h100);
`endif
    applyStimulus(mk("startxx"));
    applyStimulus(mk("0a1+002"));

    // Reset in the middle of PARSE.
    applyStimulus(mk("123-045"));
    cmd_valid = 1'b1;
    command   = mk("456+078");
    tick();
    cmd_valid = 1'b0;
    exp_ready = 0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    setExpZero();
    reset_n = 1'b1;
    tick();
    checkOutput("pin_parse_abort_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of the reset-hold window.
    applyStimulus(mk("smile"));
    predict(mk("reset"), kind, pa, pb, pop, pgo, prst, povf, pkeep);
    cmd_valid = 1'b1;
    command   = mk("reset");
    tick();
    cmd_valid = 1'b0;
    exp_ready = 0;
    tick();
    tick();
    exp_valid = 1; exp_a = pa; exp_b = pb; exp_op = pop; exp_go = pgo;
    exp_rst = prst; exp_ovf = povf;
    tick();
    reset_n = 1'b0;
    tick();
    setExpZero();
    reset_n = 1'b1;
    checkOutput("pin_hold_abort_rst", 32'(reset_out), 32'd0);
    tick();

    // Randomised traffic, with back-to-back and gapped commands.
    for (int n = 0; n < 400; n++) begin
      genCmd(rc);
      applyStimulus(rc);
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
